// File: rtl/pll_lock_supervisor.sv
// PLL bring-up supervisor: pulses the rPLL reset, waits for and qualifies lock,
// then releases the core reset; restarts on lock loss, timeout or relock request.
module pll_lock_supervisor #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int CNT_W               = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_lock,
    input  logic       relock_req,
    output logic       pll_reset,
    output logic       sys_reset,
    output logic       pll_ready,
    output logic       lock_lost,
    output logic [3:0] retry_count
);

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             sync_q, lock_s;
    logic             retry_inc, lost_nxt;

    // pll_lock comes from the PLL domain, so it is double-flopped before use
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            sync_q <= pll_lock;
            lock_s <= sync_q;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        retry_inc = 1'b0;
        lost_nxt  = 1'b0;
        unique case (state)
            PLL_RST: begin
                if (cnt == RST_LAST) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end
            end
            WAIT_LOCK: begin
                if (relock_req) begin
                    state_nxt = PLL_RST;
                    cnt_nxt   = '0;
                end else if (lock_s) begin
                    state_nxt = STABLE;
                    cnt_nxt   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_nxt = PLL_RST;
                    cnt_nxt   = '0;
                    retry_inc = 1'b1;
                end
            end
            STABLE: begin
                if (relock_req) begin
                    state_nxt = PLL_RST;
                    cnt_nxt   = '0;
                end else if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                // lock loss outranks a coincident relock request so it is always reported
                cnt_nxt = '0;
                if (!lock_s) begin
                    state_nxt = PLL_RST;
                    lost_nxt  = 1'b1;
                end else if (relock_req) begin
                    state_nxt = PLL_RST;
                end
            end
            default: begin
                state_nxt = PLL_RST;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they switch with the transition
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= PLL_RST;
            cnt         <= '0;
            pll_reset   <= 1'b1;
            sys_reset   <= 1'b1;
            pll_ready   <= 1'b0;
            lock_lost   <= 1'b0;
            retry_count <= 4'd0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            pll_reset <= (state_nxt == PLL_RST);
            sys_reset <= (state_nxt != RUN);
            pll_ready <= (state_nxt == RUN);
            lock_lost <= lost_nxt;
            if (retry_inc && (retry_count != 4'd15)) begin
                retry_count <= retry_count + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed bring-up scenarios plus randomized
// lock/relock/reset traffic, all checked against a cycle-level reference model.
module tb_pll_lock_supervisor;

    localparam int RST_N = 4;
    localparam int TMO_N = 32;
    localparam int STB_N = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pll_lock = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_reset, sys_reset, pll_ready, lock_lost;
    logic [3:0] retry_count;

    int checks = 0;
    int errors = 0;

    pll_lock_supervisor #(
        .PLL_RST_CYCLES     (RST_N),
        .LOCK_TIMEOUT_CYCLES(TMO_N),
        .LOCK_STABLE_CYCLES (STB_N),
        .CNT_W              (17)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pll_lock   (pll_lock),
        .relock_req (relock_req),
        .pll_reset  (pll_reset),
        .sys_reset  (sys_reset),
        .pll_ready  (pll_ready),
        .lock_lost  (lock_lost),
        .retry_count(retry_count)
    );

    always #5 clk = ~clk;

    // Reference model: phase plus time spent in it; lockPipe models the 2-cycle sync delay
    typedef enum int {M_RST, M_WAIT, M_STABLE, M_RUN} mphase_t;
    mphase_t mPhase;
    int      mTime;
    int      mRetry;
    bit      mLost;
    bit      lockPipe[$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mPhase   = M_RST;
        mTime    = 0;
        mRetry   = 0;
        mLost    = 0;
        lockPipe = {1'b0, 1'b0};
    endtask

    task automatic enterPhase(input mphase_t p);
        mPhase = p;
        mTime  = 0;
    endtask

    task automatic modelStep();
        bit seen;
        seen  = lockPipe[0];
        mLost = 0;
        case (mPhase)
            M_RST:
                if (mTime + 1 >= RST_N) enterPhase(M_WAIT); else mTime++;
            M_WAIT:
                if (relock_req) enterPhase(M_RST);
                else if (seen) enterPhase(M_STABLE);
                else if (mTime + 1 >= TMO_N) begin
                    enterPhase(M_RST);
                    mRetry = (mRetry < 15) ? mRetry + 1 : 15;
                end else mTime++;
            M_STABLE:
                if (relock_req) enterPhase(M_RST);
                else if (!seen) enterPhase(M_WAIT);
                else if (mTime + 1 >= STB_N) enterPhase(M_RUN);
                else mTime++;
            M_RUN:
                if (!seen) begin
                    mLost = 1;
                    enterPhase(M_RST);
                end else if (relock_req) enterPhase(M_RST);
            default: enterPhase(M_RST);
        endcase
        void'(lockPipe.pop_front());
        lockPipe.push_back(pll_lock);
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".pll_reset"}, pll_reset, (mPhase == M_RST));
        checkOutput({tag, ".sys_reset"}, sys_reset, (mPhase != M_RUN));
        checkOutput({tag, ".pll_ready"}, pll_ready, (mPhase == M_RUN));
        checkOutput({tag, ".lock_lost"}, lock_lost, mLost);
        checkOutput({tag, ".retry_count"}, retry_count, mRetry);
    endtask

    task automatic applyStimulus(input logic lockVal, input logic relockVal);
        pll_lock   = lockVal;
        relock_req = relockVal;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) modelStep();
        else mLost = 0;
        #1;
        checkAll("cycle");
    endtask

    // Asserted between edges so the outputs must respond without a clock
    task automatic assertReset();
        #2;
        reset = 1'b1;
        modelReset();
        #1;
        checkAll("async_rst");
    endtask

    task automatic waitReady(input int limit, output int edges);
        edges = 0;
        while (!pll_ready && edges < limit) begin
            tick();
            edges++;
        end
    endtask

    initial begin
        int edges;
        int fallEdge;
        int width;
        int firstRetry1, firstRetry2;
        bit released;
        bit seenLost;
        logic lockVal;
        int holdLeft;

        modelReset();
        applyStimulus(1'b1, 1'b0);
        #12;
        checkAll("reset");
        reset = 1'b0;

        // Nominal bring-up
        edges = 0;
        fallEdge = 0;
        while (!pll_ready && edges < 60) begin
            tick();
            edges++;
            if (!pll_reset && fallEdge == 0) fallEdge = edges;
        end
        checkOutput("nom_ready_edge", edges, 13);
        checkOutput("nom_prst_fall", fallEdge, 4);

        // Lock loss while running
        applyStimulus(1'b0, 1'b0);
        seenLost = 0;
        for (int i = 0; i < 10 && !seenLost; i++) begin
            tick();
            if (lock_lost) begin
                seenLost = 1;
                checkOutput("loss_sys_reset", sys_reset, 1);
                checkOutput("loss_pll_reset", pll_reset, 1);
                checkOutput("loss_ready", pll_ready, 0);
            end
        end
        checkOutput("loss_seen", seenLost, 1);
        applyStimulus(1'b1, 1'b0);
        tick();
        checkOutput("loss_one_cycle", lock_lost, 0);
        waitReady(80, edges);
        checkOutput("loss_rerun_ready", pll_ready, 1);

        // relock in RUN, then a second request inside PLL_RST
        applyStimulus(1'b1, 1'b1);
        tick();
        checkOutput("relock_no_lost", lock_lost, 0);
        checkOutput("relock_prst", pll_reset, 1);
        width = 1;
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick();
            applyStimulus(1'b1, 1'b0);
            if (pll_reset) width++;
            else break;
        end
        checkOutput("relock_prst_width", width, RST_N);
        waitReady(80, edges);
        checkOutput("relock_retry", retry_count, 0);

        // One-cycle lock glitch during qualification
        applyStimulus(1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 40 && !(mPhase == M_STABLE && mTime == 3); i++) tick();
        checkOutput("glitch_reached_stable", (mPhase == M_STABLE && mTime == 3), 1);
        applyStimulus(1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0);
        waitReady(80, edges);
        checkOutput("glitch_ready_edge", edges + 1, 12);
        checkOutput("glitch_retry", retry_count, 0);

        // Asynchronous reset while running, then the nominal sequence again
        assertReset();
        checkOutput("arst_pll_reset", pll_reset, 1);
        checkOutput("arst_sys_reset", sys_reset, 1);
        checkOutput("arst_ready", pll_ready, 0);
        tick();
        #1;
        reset = 1'b0;
        waitReady(60, edges);
        checkOutput("arst_ready_edge", edges, 13);

        // Never locks: periodic retries, saturating count
        applyStimulus(1'b0, 1'b0);
        assertReset();
        tick();
        #1;
        reset = 1'b0;
        released = 0;
        firstRetry1 = 0;
        firstRetry2 = 0;
        for (int i = 1; i <= 16 * (RST_N + TMO_N) + 40; i++) begin
            tick();
            if (!sys_reset) released = 1;
            if (retry_count == 1 && firstRetry1 == 0) firstRetry1 = i;
            if (retry_count == 2 && firstRetry2 == 0) firstRetry2 = i;
        end
        checkOutput("nolock_first_retry", firstRetry1, RST_N + TMO_N);
        checkOutput("nolock_second_retry", firstRetry2, 2 * (RST_N + TMO_N));
        checkOutput("nolock_saturate", retry_count, 15);
        checkOutput("nolock_no_release", released, 0);

        // Randomized traffic
        holdLeft = 0;
        lockVal = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if (holdLeft == 0) begin
                lockVal = ($urandom_range(0, 99) < 70);
                if (lockVal) holdLeft = $urandom_range(1, 40);
                else if ($urandom_range(0, 19) == 0) holdLeft = $urandom_range(30, 80);
                else holdLeft = $urandom_range(1, 6);
            end
            holdLeft--;
            applyStimulus(lockVal, ($urandom_range(0, 59) == 0));
            if ($urandom_range(0, 799) == 0) begin
                assertReset();
                tick();
                #1;
                reset = 1'b0;
            end else begin
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
